ahb_slave_mux: RTL and testbench
================================

Name: ahb_slave_mux

Overview:
- Slave-side address/data multiplexer that sits directly downstream of the per-slave AHB arbiter.
- Consumes the arbiter's one-hot grant and steers the granted master's address-phase signals onto the slave port.
- Holds the data-phase owner in a pipeline register so HWDATA and the slave response are routed to the correct master one phase later.
- Returns slave wait status and the active burst type to the arbiter.

Parameters:
- MASTER_NUM, 4, number of masters competing for this slave (one-hot grant width).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- hclk  in  1  clock; one clock.
- hreset  in  1  reset, synchronous and active-high.
- hgrant  in  MASTER_NUM  one-hot grant from arbiter; all-zero means no owner.
- hreq  in  MASTER_NUM  per-master request to this slave.
- m_haddr  in  MASTER_NUM x ADDR_W  per-master address.
- m_htrans  in  MASTER_NUM x 2  per-master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- m_hwrite  in  MASTER_NUM  per-master write flag.
- m_hsize  in  MASTER_NUM x 3  per-master transfer size.
- m_hburst  in  MASTER_NUM x 3  per-master burst type (hburst_type encoding).
- m_hwdata  in  MASTER_NUM x DATA_W  per-master write data.
- s_haddr  out  ADDR_W  address to slave.
- s_htrans  out  2  transfer type to slave.
- s_hwrite  out  1  write flag to slave.
- s_hsize  out  3  size to slave.
- s_hburst  out  3  burst type to slave.
- s_hwdata  out  DATA_W  write data to slave.
- s_hreadyout  in  1  slave ready.
- s_hresp  in  1  slave response (0=OKAY, 1=ERROR).
- s_hrdata  in  DATA_W  slave read data.
- m_hready  out  MASTER_NUM  per-master ready.
- m_hresp  out  MASTER_NUM  per-master response.
- m_hrdata  out  DATA_W  read data, broadcast to all masters.
- hwait  out  1  to arbiter; equals ~s_hreadyout.
- hburst  out  3  to arbiter; equals s_hburst.

Behaviour:
- Address phase (combinational):
  - aidx = index of the set bit in hgrant; aval = |hgrant.
  - When aval=1, s_haddr, s_htrans, s_hwrite, s_hsize and s_hburst take master aidx's values.
  - When aval=0, s_htrans=IDLE, s_hburst=SINGLE, and all other s_* outputs are 0.
- Data-phase register (didx, dval, dwrite):
  - Loads only when s_hreadyout=1.
  - Load values: didx<=aidx, dval<=aval & s_htrans[1], dwrite<=s_hwrite.
  - Otherwise holds.
- Data-phase FSM, states DP_IDLE / DP_ACTIVE / DP_ERR:
  - DP_IDLE -> DP_ACTIVE on a load with dval next = 1.
  - DP_ACTIVE -> DP_ERR when s_hresp=1 and s_hreadyout=0.
  - DP_ACTIVE -> DP_IDLE on s_hreadyout=1 with no new NONSEQ/SEQ accepted.
  - DP_ACTIVE stays DP_ACTIVE on s_hreadyout=1 when a new NONSEQ/SEQ is accepted (pipelined back-to-back).
  - DP_ERR -> DP_ACTIVE or DP_IDLE on s_hreadyout=1, using the same accept rule.
- Write data: s_hwdata = m_hwdata[didx] when dval & dwrite, else 0.
- Read data: m_hrdata = s_hrdata, unregistered.
- Ready and response:
  - For i==didx with dval=1: m_hready[i]=s_hreadyout and m_hresp[i]=s_hresp.
  - Else for i==aidx with aval=1: m_hready[i]=s_hreadyout and m_hresp[i]=0.
  - Else for hreq[i]=1 (ungranted requester): m_hready[i]=0, m_hresp[i]=0.
  - Otherwise: m_hready[i]=1, m_hresp[i]=0.
- Ownership handover: when aidx != didx, the address owner and the data owner each see s_hreadyout independently.
- Latency: address path 0 cycles; data-phase routing exactly 1 accepted address phase later.
- Reset (hreset=1 at posedge):
  - didx=0, dval=0, dwrite=0, FSM=DP_IDLE.
  - Outputs follow the rules above; with hgrant=0 and hreq=0: m_hready=all 1, s_htrans=IDLE.
  - Reset mid-transfer abandons the data phase, with no response to the old owner.
- Boundary conditions:
  - Non-one-hot hgrant: lowest set index wins.
  - BUSY is passed through to the slave but does not set dval.
  - A grant change while s_hreadyout=0 does not disturb didx.

Optional Feature:
- Macro GRANT_CHECK_EN. When defined, add output grant_err (1 bit).
- grant_err is a sticky flag, set on a posedge when either:
  - hgrant has more than one bit set; or
  - hgrant changes while s_hreadyout=0 and s_htrans is NONSEQ/SEQ.
- grant_err is cleared only by hreset.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset with hreset=1 for 2 cycles, hgrant=0, hreq=0 -> m_hready=4'b1111, s_htrans=0, dval=0.
- hgrant=4'b0100, m_htrans[2]=NONSEQ, m_haddr[2]=0x1000, write, s_hreadyout=1; next cycle m_hwdata[2]=0xA5A5A5A5 -> s_haddr=0x1000 in cycle 0; s_hwdata=0xA5A5A5A5 in cycle 1.
- Master 1 read in data phase, s_hreadyout=0 for 3 cycles then 1 with s_hrdata=0x12345678 -> m_hready[1]=0 for 3 cycles then 1, m_hrdata=0x12345678, hwait=1 for 3 cycles.
- Handover: hgrant changes 0001 -> 0010 on an accepted beat -> next cycle s_hwdata comes from master 0 while s_haddr comes from master 1.
- ERROR response: s_hresp=1 with s_hreadyout=0, then s_hresp=1 with s_hreadyout=1 -> m_hresp[didx]=1 both cycles, m_hready[didx]=0 then 1, FSM passes through DP_ERR.
- GRANT_CHECK_EN defined, hgrant=4'b0110 for one cycle -> grant_err=1 from the next cycle and held until hreset.

Source files
------------

// File: rtl/ahb_slave_mux.sv
// Slave-side AHB mux: steers the granted master's address phase to the slave (0 cycles) and routes wdata/ready/resp to the data owner one accepted beat later.
// Backpressure: s_hreadyout_i=0 stalls the data-phase owner and holds its register. Optional GRANT_CHECK_EN adds a sticky grant_err_o.
module ahb_slave_mux #(
  parameter int MASTER_NUM = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                         hclk_i,
  input  logic                         hreset_i,
  input  logic [MASTER_NUM-1:0]        hgrant_i,
  input  logic [MASTER_NUM-1:0]        hreq_i,
  input  logic [MASTER_NUM*ADDR_W-1:0] m_haddr_i,
  input  logic [MASTER_NUM*2-1:0]      m_htrans_i,
  input  logic [MASTER_NUM-1:0]        m_hwrite_i,
  input  logic [MASTER_NUM*3-1:0]      m_hsize_i,
  input  logic [MASTER_NUM*3-1:0]      m_hburst_i,
  input  logic [MASTER_NUM*DATA_W-1:0] m_hwdata_i,
  output logic [ADDR_W-1:0]            s_haddr_o,
  output logic [1:0]                   s_htrans_o,
  output logic                         s_hwrite_o,
  output logic [2:0]                   s_hsize_o,
  output logic [2:0]                   s_hburst_o,
  output logic [DATA_W-1:0]            s_hwdata_o,
  input  logic                         s_hreadyout_i,
  input  logic                         s_hresp_i,
  input  logic [DATA_W-1:0]            s_hrdata_i,
  output logic [MASTER_NUM-1:0]        m_hready_o,
  output logic [MASTER_NUM-1:0]        m_hresp_o,
  output logic [DATA_W-1:0]            m_hrdata_o,
  output logic                         hwait_o,
  output logic [2:0]                   hburst_o
`ifdef GRANT_CHECK_EN
  ,
  output logic                         grant_err_o
`endif
);

  localparam int IDX_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  typedef enum logic [1:0] {
    DP_IDLE   = 2'd0,
    DP_ACTIVE = 2'd1,
    DP_ERR    = 2'd2
  } dp_state_e;

  logic [IDX_W-1:0] aidx;
  logic             aval;
  logic             accept;
  logic [IDX_W-1:0] didx_q, didx_d;
  logic             dval_q, dval_d;
  logic             dwrite_q, dwrite_d;
  dp_state_e        state_q, state_d;
  logic             dp_own;

  // Descending scan so a non-one-hot grant resolves to the lowest set index.
  always_comb begin
    aidx = '0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (hgrant_i[i]) aidx = IDX_W'(i);
    end
  end

  assign aval = |hgrant_i;

  always_comb begin
    s_haddr_o  = '0;
    s_htrans_o = 2'd0;
    s_hwrite_o = 1'b0;
    s_hsize_o  = 3'd0;
    s_hburst_o = 3'd0;
    if (aval) begin
      s_haddr_o  = m_haddr_i[aidx*ADDR_W +: ADDR_W];
      s_htrans_o = m_htrans_i[aidx*2 +: 2];
      s_hwrite_o = m_hwrite_i[aidx];
      s_hsize_o  = m_hsize_i[aidx*3 +: 3];
      s_hburst_o = m_hburst_i[aidx*3 +: 3];
    end
  end

  // BUSY/IDLE beats never open a data phase.
  assign accept = s_hreadyout_i & aval & s_htrans_o[1];

  always_comb begin
    didx_d   = didx_q;
    dval_d   = dval_q;
    dwrite_d = dwrite_q;
    if (s_hreadyout_i) begin
      didx_d   = aidx;
      dval_d   = aval & s_htrans_o[1];
      dwrite_d = s_hwrite_o;
    end
  end

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      didx_q   <= '0;
      dval_q   <= 1'b0;
      dwrite_q <= 1'b0;
      state_q  <= DP_IDLE;
    end else begin
      didx_q   <= didx_d;
      dval_q   <= dval_d;
      dwrite_q <= dwrite_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DP_IDLE:   if (accept) state_d = DP_ACTIVE;
      DP_ACTIVE: begin
        if (s_hresp_i && !s_hreadyout_i) state_d = DP_ERR;
        else if (s_hreadyout_i)          state_d = accept ? DP_ACTIVE : DP_IDLE;
      end
      DP_ERR:    if (s_hreadyout_i) state_d = accept ? DP_ACTIVE : DP_IDLE;
      default:   state_d = DP_IDLE;
    endcase
  end

  // Data owner takes priority over the address owner when they are the same master.
  always_comb begin
    dp_own     = (state_q != DP_IDLE);
    m_hready_o = '1;
    m_hresp_o  = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (dp_own && (IDX_W'(i) == didx_q)) begin
        m_hready_o[i] = s_hreadyout_i;
        m_hresp_o[i]  = s_hresp_i;
      end else if (aval && (IDX_W'(i) == aidx)) begin
        m_hready_o[i] = s_hreadyout_i;
      end else if (hreq_i[i]) begin
        m_hready_o[i] = 1'b0;
      end
    end
  end

  assign s_hwdata_o = (dval_q && dwrite_q) ? m_hwdata_i[didx_q*DATA_W +: DATA_W] : '0;
  assign m_hrdata_o = s_hrdata_i;
  assign hwait_o    = ~s_hreadyout_i;
  assign hburst_o   = s_hburst_o;

`ifdef GRANT_CHECK_EN
  logic [MASTER_NUM-1:0] hgrant_q;
  logic                  grant_err_q;

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      hgrant_q    <= '0;
      grant_err_q <= 1'b0;
    end else begin
      hgrant_q <= hgrant_i;
      if (((hgrant_i & (hgrant_i - MASTER_NUM'(1))) != '0) ||
          ((hgrant_i != hgrant_q) && !s_hreadyout_i && s_htrans_o[1]))
        grant_err_q <= 1'b1;
    end
  end

  assign grant_err_o = grant_err_q;
`endif

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed bench for ahb_slave_mux: hand-computed vectors for address steering, data-phase routing, waits, errors and reset.
module tb_ahb_slave_mux;
  localparam int MN = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [MN-1:0] hgrant, hreq;
  logic [MN*AW-1:0] m_haddr;
  logic [MN*2-1:0]  m_htrans;
  logic [MN-1:0]    m_hwrite;
  logic [MN*3-1:0]  m_hsize, m_hburst;
  logic [MN*DW-1:0] m_hwdata;
  logic [AW-1:0] s_haddr;
  logic [1:0]    s_htrans;
  logic          s_hwrite;
  logic [2:0]    s_hsize, s_hburst;
  logic [DW-1:0] s_hwdata;
  logic          s_hreadyout, s_hresp;
  logic [DW-1:0] s_hrdata;
  logic [MN-1:0] m_hready, m_hresp;
  logic [DW-1:0] m_hrdata;
  logic          hwait;
  logic [2:0]    hburst;
`ifdef GRANT_CHECK_EN
  logic          grant_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mux #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk_i(hclk), .hreset_i(hreset), .hgrant_i(hgrant), .hreq_i(hreq),
    .m_haddr_i(m_haddr), .m_htrans_i(m_htrans), .m_hwrite_i(m_hwrite),
    .m_hsize_i(m_hsize), .m_hburst_i(m_hburst), .m_hwdata_i(m_hwdata),
    .s_haddr_o(s_haddr), .s_htrans_o(s_htrans), .s_hwrite_o(s_hwrite),
    .s_hsize_o(s_hsize), .s_hburst_o(s_hburst), .s_hwdata_o(s_hwdata),
    .s_hreadyout_i(s_hreadyout), .s_hresp_i(s_hresp), .s_hrdata_i(s_hrdata),
    .m_hready_o(m_hready), .m_hresp_o(m_hresp), .m_hrdata_o(m_hrdata),
    .hwait_o(hwait), .hburst_o(hburst)
`ifdef GRANT_CHECK_EN
    , .grant_err_o(grant_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic [31:0] addr, input logic [1:0] tr,
                       input logic wr, input logic [31:0] wd);
    m_haddr[m*AW +: AW]  = addr;
    m_htrans[m*2 +: 2]   = tr;
    m_hwrite[m]          = wr;
    m_hsize[m*3 +: 3]    = 3'd2;
    m_hburst[m*3 +: 3]   = 3'd1;
    m_hwdata[m*DW +: DW] = wd;
  endtask

  task automatic idle_all();
    for (int m = 0; m < MN; m++) m_htrans[m*2 +: 2] = 2'd0;
    hgrant = '0;
    hreq   = '0;
  endtask

  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  initial begin
    hreset = 1'b1; hgrant = '0; hreq = '0;
    m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0; m_hburst = '0; m_hwdata = '0;
    s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;

    // reset
    tick(); tick();
    #1;
    chk("rst_hready", 64'(m_hready), 64'hF);
    chk("rst_htrans", 64'(s_htrans), 64'h0);
    chk("rst_hwdata", 64'(s_hwdata), 64'h0);
    chk("rst_state", 64'(dut.state_q), 64'h0);
    hreset = 1'b0;
    tick();

    // single write from master 2
    hgrant = 4'b0100; hreq = 4'b0100;
    set_m(2, 32'h1000, 2'd2, 1'b1, 32'h0);
    #1;
    chk("wr_haddr", 64'(s_haddr), 64'h1000);
    chk("wr_htrans", 64'(s_htrans), 64'h2);
    chk("wr_hwrite", 64'(s_hwrite), 64'h1);
    chk("wr_hburst", 64'(hburst), 64'h1);
    chk("wr_hready", 64'(m_hready), 64'hF);
    tick();
    idle_all();
    m_hwdata[2*DW +: DW] = 32'hA5A5A5A5;
    #1;
    chk("wr_hwdata", 64'(s_hwdata), 64'hA5A5A5A5);
    chk("wr_idle_htrans", 64'(s_htrans), 64'h0);
    tick();
    #1;
    chk("wr_done_hwdata", 64'(s_hwdata), 64'h0);

    // read from master 1 with three wait states
    hgrant = 4'b0010; hreq = 4'b0010;
    set_m(1, 32'h2000, 2'd2, 1'b0, 32'hDEADBEEF);
    tick();
    idle_all();
    s_hreadyout = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rd_wait_hready1", 64'(m_hready[1]), 64'h0);
      chk("rd_wait_hwait", 64'(hwait), 64'h1);
      tick();
    end
    s_hreadyout = 1'b1; s_hrdata = 32'h12345678;
    #1;
    chk("rd_hready1", 64'(m_hready[1]), 64'h1);
    chk("rd_hrdata", 64'(m_hrdata), 64'h12345678);
    chk("rd_hwait", 64'(hwait), 64'h0);
    chk("rd_no_hwdata", 64'(s_hwdata), 64'h0);
    tick();

    // handover 0 -> 1, then grant change under wait to master 2
    hgrant = 4'b0001; hreq = 4'b0011;
    set_m(0, 32'h3000, 2'd2, 1'b1, 32'h0000AAAA);
    set_m(1, 32'h4000, 2'd2, 1'b1, 32'h0000BBBB);
    #1;
    chk("ho_haddr0", 64'(s_haddr), 64'h3000);
    chk("ho_hready_req", 64'(m_hready), 64'hD);
    tick();
    hgrant = 4'b0010;
    #1;
    chk("ho_haddr1", 64'(s_haddr), 64'h4000);
    chk("ho_hwdata0", 64'(s_hwdata), 64'h0000AAAA);
    chk("ho_hready", 64'(m_hready), 64'hF);
    tick();
    hgrant = 4'b0100; hreq = 4'b0100;
    set_m(2, 32'h5000, 2'd2, 1'b1, 32'h0000CCCC);
    s_hreadyout = 1'b0;
    #1;
    chk("ho_hwdata1", 64'(s_hwdata), 64'h0000BBBB);
    chk("ho_wait_hready", 64'(m_hready), 64'h9);
    tick();
    #1;
    chk("ho_hold_hwdata1", 64'(s_hwdata), 64'h0000BBBB);
    s_hreadyout = 1'b1;
    tick();
    idle_all();
    #1;
    chk("ho_hwdata2", 64'(s_hwdata), 64'h0000CCCC);
    tick();

    // BUSY passes through but opens no data phase
    hgrant = 4'b0001; hreq = 4'b0001;
    set_m(0, 32'h6000, 2'd1, 1'b1, 32'h11111111);
    #1;
    chk("busy_htrans", 64'(s_htrans), 64'h1);
    tick();
    hgrant = '0; hreq = '0;
    #1;
    chk("busy_hwdata", 64'(s_hwdata), 64'h0);
    chk("busy_state", 64'(dut.state_q), 64'h0);
    idle_all();
    tick();

    // two-cycle ERROR response to master 2
    hgrant = 4'b0100; hreq = 4'b0100;
    set_m(2, 32'h7000, 2'd2, 1'b0, 32'h0);
    tick();
    idle_all();
    s_hreadyout = 1'b0; s_hresp = 1'b1;
    #1;
    chk("err1_hresp2", 64'(m_hresp[2]), 64'h1);
    chk("err1_hready2", 64'(m_hready[2]), 64'h0);
    tick();
    chk("err_state", 64'(dut.state_q), 64'h2);
    s_hreadyout = 1'b1;
    #1;
    chk("err2_hresp2", 64'(m_hresp[2]), 64'h1);
    chk("err2_hready2", 64'(m_hready[2]), 64'h1);
    tick();
    s_hresp = 1'b0;
    #1;
    chk("err_idle_state", 64'(dut.state_q), 64'h0);
    chk("err_idle_hresp", 64'(m_hresp), 64'h0);

    // reset in the middle of a data phase
    hgrant = 4'b0001; hreq = 4'b0001;
    set_m(0, 32'h8000, 2'd2, 1'b1, 32'h22222222);
    tick();
    idle_all();
    hreset = 1'b1; s_hreadyout = 1'b0; s_hresp = 1'b1;
    tick();
    #1;
    chk("mrst_hready", 64'(m_hready), 64'hF);
    chk("mrst_hresp", 64'(m_hresp), 64'h0);
    chk("mrst_hwdata", 64'(s_hwdata), 64'h0);
`ifdef GRANT_CHECK_EN
    chk("mrst_grant_err", 64'(grant_err), 64'h0);
`endif
    hreset = 1'b0; s_hreadyout = 1'b1; s_hresp = 1'b0;
    tick();

    // non-one-hot grant: lowest index wins
    hgrant = 4'b0110;
    set_m(1, 32'h9100, 2'd2, 1'b0, 32'h0);
    set_m(2, 32'h9200, 2'd2, 1'b0, 32'h0);
    #1;
    chk("multi_haddr", 64'(s_haddr), 64'h9100);
    tick();
    idle_all();
    #1;
`ifdef GRANT_CHECK_EN
    chk("gerr_set", 64'(grant_err), 64'h1);
    tick(); tick();
    chk("gerr_hold", 64'(grant_err), 64'h1);
    hreset = 1'b1;
    tick();
    chk("gerr_clr", 64'(grant_err), 64'h0);
    hreset = 1'b0;
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
